// File: rtl/lpc_io_reg_writer_pkg.sv
// Shared LPC constants and FSM state encoding for the I/O-write register writer.
package lpc_io_reg_writer_pkg;

  localparam logic [3:0] LPC_START     = 4'h0;
  localparam logic [3:0] CYCTYPE_IO_WR = 4'b0010;
  localparam logic [3:0] SYNC_READY    = 4'h0;
  localparam logic [3:0] TAR_NIBBLE    = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYCT,
    ST_ADDR,
    ST_DATA0,
    ST_DATA1,
    ST_TAR0,
    ST_TAR1,
    ST_SYNC,
    ST_TAR2
  } lpc_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lpc_addr_decode.sv
// Combinational window decode: I/O address -> hit flag, register index and byte lane.
module lpc_addr_decode
  import lpc_io_reg_writer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0600,
  parameter int          NREG      = 10,
  localparam int         IDX_W     = idx_width(NREG)
) (
  input  logic [15:0]      i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx,
  output logic [1:0]       o_lane
);

  logic [15:0] w_off;
  logic [16:0] w_end;

  assign w_off = i_addr - BASE_ADDR;
  // 17-bit end bound so a window touching 16'hFFFF cannot wrap to zero.
  assign w_end = {1'b0, BASE_ADDR} + 17'(NREG * 4);

  assign o_hit  = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} < w_end);
  assign o_idx  = IDX_W'(w_off >> 2);
  assign o_lane = w_off[1:0];

endmodule

// File: rtl/lpc_io_reg_writer.sv
// LPC peripheral I/O-write decoder: packs byte writes into a shadow word and
// commits it to a one-hot register file on each lane-3 write.
module lpc_io_reg_writer
  import lpc_io_reg_writer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0600,
  parameter int          NREG      = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            lframe_n,
  input  logic [3:0]      lad_in,
  output logic [3:0]      lad_out,
  output logic            lad_oe,
  output logic [NREG-1:0] wsel,
  output logic [31:0]     din
);

  localparam int IDX_W = idx_width(NREG);

  lpc_state_e       r_state;
  lpc_state_e       w_next_state;
  logic [15:0]      r_addr;
  logic [1:0]       r_nib_cnt;
  logic [3:0]       r_data_lo;
  logic [31:0]      r_shadow;
  logic [NREG-1:0]  r_wsel;
  logic             r_lad_oe;
  logic [3:0]       r_lad_out;

  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic [NREG-1:0]  w_onehot;

  lpc_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NREG      (NREG)
  ) u_addr_decode (
    .i_addr (r_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_lane (w_lane)
  );

  assign w_onehot = NREG'(1) << w_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state; no latch is inferred.
    w_next_state = r_state;
    if (!lframe_n) begin
      // LFRAME# low aborts whatever is in flight; it may also be a fresh START.
      w_next_state = (lad_in == LPC_START) ? ST_CYCT : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = ST_IDLE;
        ST_CYCT:  w_next_state = (lad_in == CYCTYPE_IO_WR) ? ST_ADDR : ST_IDLE;
        ST_ADDR:  w_next_state = (r_nib_cnt == 2'd3) ? ST_DATA0 : ST_ADDR;
        ST_DATA0: w_next_state = ST_DATA1;
        ST_DATA1: w_next_state = w_hit ? ST_TAR0 : ST_IDLE;
        ST_TAR0:  w_next_state = ST_TAR1;
        ST_TAR1:  w_next_state = ST_SYNC;
        ST_SYNC:  w_next_state = ST_TAR2;
        ST_TAR2:  w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_nib_cnt <= '0;
      r_data_lo <= '0;
      r_shadow  <= '0;
      r_wsel    <= '0;
      r_lad_oe  <= 1'b0;
      r_lad_out <= TAR_NIBBLE;
    end else begin
      if (r_state == ST_CYCT) r_nib_cnt <= '0;
      if (r_state == ST_ADDR) begin
        r_addr    <= {r_addr[11:0], lad_in};
        r_nib_cnt <= r_nib_cnt + 2'd1;
      end
      if (r_state == ST_DATA0) r_data_lo <= lad_in;

      // Entering TAR0 only happens from DATA1 on an uninterrupted hit.
      if (w_next_state == ST_TAR0) r_shadow[{w_lane, 3'b000} +: 8] <= {lad_in, r_data_lo};
      r_wsel    <= ((w_next_state == ST_TAR0) && (w_lane == 2'd3)) ? w_onehot : '0;

      r_lad_oe  <= (w_next_state == ST_SYNC) || (w_next_state == ST_TAR2);
      r_lad_out <= (w_next_state == ST_SYNC) ? SYNC_READY : TAR_NIBBLE;
    end
  end

  assign lad_out = r_lad_out;
  assign lad_oe  = r_lad_oe;
  assign wsel    = r_wsel;
  assign din     = r_shadow;

endmodule

// File: tb/tb_lpc_io_reg_writer.sv
// Self-checking bench: drives LPC I/O cycles and compares each clock against a
// transaction-level model of the shadow word, commit strobes and SYNC drive.
module tb_lpc_io_reg_writer;

  localparam logic [15:0] BASE = 16'h0600;
  localparam int          NREG = 10;
  localparam int          NCLK = 12;

  logic            clk;
  logic            reset_n;
  logic            lframe_n;
  logic [3:0]      lad_in;
  logic [3:0]      lad_out;
  logic            lad_oe;
  logic [NREG-1:0] wsel;
  logic [31:0]     din;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-clock observations of the last cycle, indexed by host clock number.
  logic [NREG-1:0] obs_wsel [NCLK];
  logic            obs_oe   [NCLK];
  logic [3:0]      obs_out  [NCLK];
  logic [31:0]     obs_din  [NCLK];

  // Model: byte-addressed shadow plus the expected per-clock trace.
  logic [7:0]      m_sh     [4];
  logic [NREG-1:0] exp_wsel [NCLK];
  logic            exp_oe   [NCLK];
  logic [3:0]      exp_out  [NCLK];
  logic [31:0]     exp_din;
  int              exp_len;

  lpc_io_reg_writer #(
    .BASE_ADDR (BASE),
    .NREG      (NREG)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .lframe_n (lframe_n),
    .lad_in   (lad_in),
    .lad_out  (lad_out),
    .lad_oe   (lad_oe),
    .wsel     (wsel),
    .din      (din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  // Host clock i: 0 START, 1 cycle type, 2-5 address MSB first, 6-7 data, 8-11 host idle.
  // abort_at replaces that clock with LFRAME# low and a non-START nibble.
  task automatic lpc_cycle(input logic [15:0] addr, input logic [7:0] data,
                           input logic [3:0] cyc, input int abort_at, input int stop_at);
    logic       lf;
    logic [3:0] nib;
    for (int i = 0; i <= stop_at; i++) begin
      lf  = 1'b1;
      nib = 4'hF;
      case (i)
        0:          begin lf = 1'b0; nib = 4'h0; end
        1:          nib = cyc;
        2, 3, 4, 5: nib = addr[4*(5-i) +: 4];
        6:          nib = data[3:0];
        7:          nib = data[7:4];
        default:    nib = 4'hF;
      endcase
      if (i == abort_at) begin
        lf  = 1'b0;
        nib = 4'hF;
      end
      @(negedge clk);
      lframe_n = lf;
      lad_in   = nib;
      @(posedge clk);
      #1;
      obs_wsel[i] = wsel;
      obs_oe[i]   = lad_oe;
      obs_out[i]  = lad_out;
      obs_din[i]  = din;
      if (i == abort_at) break;
    end
  endtask

  // Transaction-level expectation: a completed I/O write inside the window
  // stores its byte; lane 3 strobes its register during TAR0; SYNC/TAR2 drive.
  function automatic void model_cycle(input logic [15:0] addr, input logic [7:0] data,
                                      input logic [3:0] cyc, input int abort_at);
    int  off;
    bit  hit;
    bit  full;
    exp_len = (abort_at >= 0) ? abort_at + 1 : NCLK;
    for (int i = 0; i < NCLK; i++) begin
      exp_wsel[i] = '0;
      exp_oe[i]   = 1'b0;
      exp_out[i]  = 4'hF;
    end
    hit  = (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + 4 * NREG);
    full = (cyc == 4'h2) && hit && (abort_at < 0 || abort_at > 7);
    if (full) begin
      off = int'(addr) - int'(BASE);
      m_sh[off % 4] = data;
      if (off % 4 == 3) exp_wsel[7] = NREG'(1) << (off / 4);
    end
    if (full && (abort_at < 0 || abort_at > 9)) begin
      exp_oe[9]  = 1'b1;
      exp_out[9] = 4'h0;
    end
    if (full && (abort_at < 0 || abort_at > 10)) begin
      exp_oe[10]  = 1'b1;
      exp_out[10] = 4'hF;
    end
    exp_din = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int b = 0; b < 4; b++) m_sh[b] = 8'h00;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    n_checks++; if (lad_oe !== 1'b0)   $display("FAIL reset lad_oe: got %b expected 0", lad_oe);   else n_pass++;
    n_checks++; if (lad_out !== 4'hF)  $display("FAIL reset lad_out: got %h expected f", lad_out); else n_pass++;
    n_checks++; if (wsel !== '0)       $display("FAIL reset wsel: got %h expected 000", wsel);     else n_pass++;
    n_checks++; if (din !== 32'h0)     $display("FAIL reset din: got %h expected 00000000", din);  else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int b = 0; b < 4; b++) m_sh[b] = 8'h00;
  endtask

  task automatic test_lane_fill;
    for (int t = 0; t < 4; t++) begin
      lpc_cycle(BASE + 16'h4 + 16'(t), 8'(17 * (t + 1)), 4'h2, -1, NCLK - 1);
      model_cycle(BASE + 16'h4 + 16'(t), 8'(17 * (t + 1)), 4'h2, -1);
      for (int i = 0; i < exp_len; i++) begin
        n_checks++;
        if (obs_wsel[i] !== exp_wsel[i]) $display("FAIL lane_fill wsel t%0d clk%0d: got %h expected %h", t, i, obs_wsel[i], exp_wsel[i]);
        else n_pass++;
        n_checks++;
        if (obs_oe[i] !== exp_oe[i]) $display("FAIL lane_fill lad_oe t%0d clk%0d: got %b expected %b", t, i, obs_oe[i], exp_oe[i]);
        else n_pass++;
        if (exp_oe[i]) begin
          n_checks++;
          if (obs_out[i] !== exp_out[i]) $display("FAIL lane_fill lad_out t%0d clk%0d: got %h expected %h", t, i, obs_out[i], exp_out[i]);
          else n_pass++;
        end
      end
      n_checks++;
      if (obs_din[exp_len-1] !== exp_din) $display("FAIL lane_fill din t%0d: got %h expected %h", t, obs_din[exp_len-1], exp_din);
      else n_pass++;
    end
    n_checks++; if (obs_wsel[7] !== 10'h002)  $display("FAIL lane_fill commit wsel: got %h expected 002", obs_wsel[7]);      else n_pass++;
    n_checks++; if (obs_din[7] !== 32'h44332211) $display("FAIL lane_fill commit din: got %h expected 44332211", obs_din[7]); else n_pass++;
  endtask

  task automatic test_window_edges;
    logic [15:0] a [4] = '{16'h0627, 16'h0628, 16'h05FF, 16'h0600};
    logic [7:0]  d [4] = '{8'hAB, 8'h12, 8'h34, 8'h5C};
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      lpc_cycle(a[t], d[t], 4'h2, -1, NCLK - 1);
      model_cycle(a[t], d[t], 4'h2, -1);
      for (int i = 0; i < exp_len; i++) begin
        n_checks++;
        if (obs_wsel[i] !== exp_wsel[i]) $display("FAIL window wsel addr %h clk%0d: got %h expected %h", a[t], i, obs_wsel[i], exp_wsel[i]);
        else n_pass++;
        n_checks++;
        if (obs_oe[i] !== exp_oe[i]) $display("FAIL window lad_oe addr %h clk%0d: got %b expected %b", a[t], i, obs_oe[i], exp_oe[i]);
        else n_pass++;
        if (exp_oe[i]) begin
          n_checks++;
          if (obs_out[i] !== exp_out[i]) $display("FAIL window lad_out addr %h clk%0d: got %h expected %h", a[t], i, obs_out[i], exp_out[i]);
          else n_pass++;
        end
      end
      n_checks++;
      if (obs_din[exp_len-1] !== exp_din) $display("FAIL window din addr %h: got %h expected %h", a[t], obs_din[exp_len-1], exp_din);
      else n_pass++;
      if (t == 0) begin
        n_checks++; if (obs_wsel[7] !== 10'h200)     $display("FAIL window top wsel: got %h expected 200", obs_wsel[7]);     else n_pass++;
        n_checks++; if (obs_din[7] !== 32'hAB000000) $display("FAIL window top din: got %h expected ab000000", obs_din[7]); else n_pass++;
      end
    end
  endtask

  task automatic test_other_cycles;
    logic [3:0] c [3] = '{4'h0, 4'h4, 4'h3};
    for (int t = 0; t < 3; t++) begin
      lpc_cycle(16'h0607, 8'h5E, c[t], -1, NCLK - 1);
      model_cycle(16'h0607, 8'h5E, c[t], -1);
      for (int i = 0; i < exp_len; i++) begin
        n_checks++;
        if (obs_wsel[i] !== exp_wsel[i]) $display("FAIL cyctype %h wsel clk%0d: got %h expected %h", c[t], i, obs_wsel[i], exp_wsel[i]);
        else n_pass++;
        n_checks++;
        if (obs_oe[i] !== exp_oe[i]) $display("FAIL cyctype %h lad_oe clk%0d: got %b expected %b", c[t], i, obs_oe[i], exp_oe[i]);
        else n_pass++;
      end
      n_checks++;
      if (obs_din[exp_len-1] !== exp_din) $display("FAIL cyctype %h din: got %h expected %h", c[t], obs_din[exp_len-1], exp_din);
      else n_pass++;
    end
  endtask

  task automatic test_abort;
    logic [15:0] a  [3] = '{16'h0613, 16'h060F, 16'h061B};
    int          ab [3] = '{3, 10, 7};
    for (int t = 0; t < 3; t++) begin
      lpc_cycle(a[t], 8'h96 + 8'(t), 4'h2, ab[t], NCLK - 1);
      model_cycle(a[t], 8'h96 + 8'(t), 4'h2, ab[t]);
      for (int i = 0; i < exp_len; i++) begin
        n_checks++;
        if (obs_wsel[i] !== exp_wsel[i]) $display("FAIL abort@%0d wsel clk%0d: got %h expected %h", ab[t], i, obs_wsel[i], exp_wsel[i]);
        else n_pass++;
        n_checks++;
        if (obs_oe[i] !== exp_oe[i]) $display("FAIL abort@%0d lad_oe clk%0d: got %b expected %b", ab[t], i, obs_oe[i], exp_oe[i]);
        else n_pass++;
        if (exp_oe[i]) begin
          n_checks++;
          if (obs_out[i] !== exp_out[i]) $display("FAIL abort@%0d lad_out clk%0d: got %h expected %h", ab[t], i, obs_out[i], exp_out[i]);
          else n_pass++;
        end
      end
      n_checks++;
      if (obs_din[exp_len-1] !== exp_din) $display("FAIL abort@%0d din: got %h expected %h", ab[t], obs_din[exp_len-1], exp_din);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a;
    logic [7:0]  d;
    logic [3:0]  c;
    int          ab;
    for (int t = 0; t < 48; t++) begin
      a  = 16'h05F8 + 16'($urandom_range(0, 64));
      d  = 8'($urandom);
      c  = ($urandom_range(0, 7) == 0) ? 4'h4 : 4'h2;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 11)) : -1;
      lpc_cycle(a, d, c, ab, NCLK - 1);
      model_cycle(a, d, c, ab);
      for (int i = 0; i < exp_len; i++) begin
        n_checks++;
        if (obs_wsel[i] !== exp_wsel[i]) $display("FAIL b2b wsel t%0d addr %h clk%0d: got %h expected %h", t, a, i, obs_wsel[i], exp_wsel[i]);
        else n_pass++;
        n_checks++;
        if (obs_oe[i] !== exp_oe[i]) $display("FAIL b2b lad_oe t%0d addr %h clk%0d: got %b expected %b", t, a, i, obs_oe[i], exp_oe[i]);
        else n_pass++;
        if (exp_oe[i]) begin
          n_checks++;
          if (obs_out[i] !== exp_out[i]) $display("FAIL b2b lad_out t%0d clk%0d: got %h expected %h", t, i, obs_out[i], exp_out[i]);
          else n_pass++;
        end
      end
      n_checks++;
      if (obs_din[exp_len-1] !== exp_din) $display("FAIL b2b din t%0d addr %h: got %h expected %h", t, a, obs_din[exp_len-1], exp_din);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    // Reset between edges while the FSM sits in DATA1 (after host clock 6).
    lpc_cycle(16'h0602, 8'h5A, 4'h2, -1, NCLK - 1);
    model_cycle(16'h0602, 8'h5A, 4'h2, -1);
    lpc_cycle(16'h0603, 8'h77, 4'h2, -1, 6);
    n_checks++; if (din !== exp_din) $display("FAIL async_data1 pre din: got %h expected %h", din, exp_din); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (lad_oe !== 1'b0) $display("FAIL async_data1 lad_oe: got %b expected 0", lad_oe); else n_pass++;
    n_checks++; if (wsel !== '0)     $display("FAIL async_data1 wsel: got %h expected 000", wsel);   else n_pass++;
    n_checks++; if (din !== 32'h0)   $display("FAIL async_data1 din: got %h expected 00000000", din); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int b = 0; b < 4; b++) m_sh[b] = 8'h00;

    // Reset between edges while the FSM drives SYNC (after host clock 9).
    lpc_cycle(16'h060B, 8'hC3, 4'h2, -1, 9);
    model_cycle(16'h060B, 8'hC3, 4'h2, -1);
    n_checks++; if (obs_wsel[7] !== exp_wsel[7]) $display("FAIL async_sync commit wsel: got %h expected %h", obs_wsel[7], exp_wsel[7]); else n_pass++;
    n_checks++; if (obs_oe[9] !== 1'b1)          $display("FAIL async_sync pre lad_oe: got %b expected 1", obs_oe[9]);                 else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (lad_oe !== 1'b0) $display("FAIL async_sync lad_oe: got %b expected 0", lad_oe);  else n_pass++;
    n_checks++; if (wsel !== '0)     $display("FAIL async_sync wsel: got %h expected 000", wsel);    else n_pass++;
    n_checks++; if (din !== 32'h0)   $display("FAIL async_sync din: got %h expected 00000000", din); else n_pass++;
    @(negedge clk);
    lframe_n = 1'b1;
    lad_in   = 4'hF;
    reset_n  = 1'b1;
    for (int b = 0; b < 4; b++) m_sh[b] = 8'h00;

    test_lane_fill();
  endtask

  initial begin
    lframe_n = 1'b1;
    lad_in   = 4'hF;
    reset_n  = 1'b1;
    for (int b = 0; b < 4; b++) m_sh[b] = 8'h00;
    #1;
    test_reset();
    test_lane_fill();
    test_window_edges();
    test_other_cycles();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
